// File: rtl/pla_out_activity_monitor.sv
// Switching-activity monitor for the 7-output PLA stage: counts per-bit and total output toggles over a window.
// Latency: a counter update is visible on rd_data two cycles after its acceptance. done pulses in the cycle after the final acceptance.
// Backpressure: in_ready depends on state only; it is high in ARMED/RUN and low otherwise. Optional histogram: ACTIVITY_HAMMING_HIST_EN.
module pla_out_activity_monitor #(
  parameter int OUT_W  = 7,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] in_vec,
  output logic             busy,
  output logic             done,
  output logic             sat,
  input  logic [3:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data
);

  // The sample counter must reach WINDOW even when WINDOW exceeds the counter width.
  localparam int SMP_W = ($clog2(WINDOW + 1) > CNT_W) ? $clog2(WINDOW + 1) : CNT_W;
  localparam int PC_W  = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SMP_W-1:0] WIN_C   = SMP_W'(WINDOW);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_REPORT} state_t;

  state_t             state_q;
  logic               in_ready_q, busy_q, done_q, sat_q;
  logic [OUT_W-1:0]   prev_q;
  logic [CNT_W-1:0]   cnt_q [OUT_W];
  logic [CNT_W-1:0]   total_q;
  logic [SMP_W-1:0]   samples_q;
  logic [CNT_W-1:0]   rd_data_q;

  logic               accept;
  logic [OUT_W-1:0]   toggle;
  logic [PC_W-1:0]    pop;
  logic [CNT_W-1:0]   cnt_d [OUT_W];
  logic [CNT_W:0]     total_sum;
  logic [CNT_W-1:0]   total_d;
  logic [SMP_W-1:0]   samples_d;
  logic               ovf;
  logic [CNT_W-1:0]   rd_data_d;

`ifdef ACTIVITY_HAMMING_HIST_EN
  logic [CNT_W-1:0]   hist_q [OUT_W+1];
  logic [CNT_W-1:0]   hist_d [OUT_W+1];
`endif

  assign accept   = in_valid & in_ready_q;
  assign toggle   = prev_q ^ in_vec;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sat      = sat_q;
  assign rd_data  = rd_data_q;

  // Hamming distance between the previous and the incoming vector.
  always_comb begin
    pop = '0;
    for (int i = 0; i < OUT_W; i++) begin
      pop = pop + PC_W'(toggle[i]);
    end
  end

  // Saturating next values for one RUN acceptance; ovf flags any counter that would wrap.
  always_comb begin
    ovf = 1'b0;
    for (int i = 0; i < OUT_W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (toggle[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    total_sum = {1'b0, total_q} + (CNT_W+1)'(pop);
    total_d   = total_sum[CNT_W] ? CNT_MAX : total_sum[CNT_W-1:0];
    if (total_sum[CNT_W]) ovf = 1'b1;
    samples_d = samples_q + 1'b1;
`ifdef ACTIVITY_HAMMING_HIST_EN
    for (int k = 0; k <= OUT_W; k++) begin
      hist_d[k] = hist_q[k];
      if (pop == PC_W'(k)) begin
        if (hist_q[k] == CNT_MAX) ovf = 1'b1;
        else                      hist_d[k] = hist_q[k] + 1'b1;
      end
    end
`endif
  end

  // Result select; the samples address keeps priority over a histogram bin that aliases it.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (rd_addr == 4'(i)) rd_data_d = cnt_q[i];
    end
`ifdef ACTIVITY_HAMMING_HIST_EN
    for (int k = 0; k <= OUT_W; k++) begin
      if ((8 + k) <= 15 && rd_addr == 4'(8 + k)) rd_data_d = hist_q[k];
    end
`endif
    if (rd_addr == 4'(OUT_W))     rd_data_d = total_q;
    if (rd_addr == 4'(OUT_W + 1)) rd_data_d = samples_q[CNT_W-1:0];
  end

  // Window FSM with registered handshake/status outputs and the activity counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      prev_q     <= '0;
      total_q    <= '0;
      samples_q  <= '0;
      for (int i = 0; i < OUT_W; i++) cnt_q[i] <= '0;
`ifdef ACTIVITY_HAMMING_HIST_EN
      for (int k = 0; k <= OUT_W; k++) hist_q[k] <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_ARMED;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            sat_q      <= 1'b0;
            total_q    <= '0;
            samples_q  <= '0;
            for (int i = 0; i < OUT_W; i++) cnt_q[i] <= '0;
`ifdef ACTIVITY_HAMMING_HIST_EN
            for (int k = 0; k <= OUT_W; k++) hist_q[k] <= '0;
`endif
          end
        end
        S_ARMED: begin
          // First vector only establishes the reference for toggle detection.
          if (accept) begin
            prev_q    <= in_vec;
            samples_q <= SMP_W'(1);
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            for (int i = 0; i < OUT_W; i++) cnt_q[i] <= cnt_d[i];
`ifdef ACTIVITY_HAMMING_HIST_EN
            for (int k = 0; k <= OUT_W; k++) hist_q[k] <= hist_d[k];
`endif
            total_q   <= total_d;
            prev_q    <= in_vec;
            samples_q <= samples_d;
            if (ovf) sat_q <= 1'b1;
            if (samples_d == WIN_C) begin
              state_q    <= S_REPORT;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        S_REPORT: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Registered read port, usable in every state.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

endmodule

// File: tb/tb_pla_out_activity_monitor.sv
module tb_pla_out_activity_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, in_valid, in_ready, busy, done, sat;
  logic [6:0] in_vec;
  logic [3:0] rd_addr;
  logic [15:0] rd_data;

  logic s_start, s_in_valid, s_in_ready, s_busy, s_done, s_sat;
  logic [6:0] s_in_vec;
  logic [3:0] s_rd_addr;
  logic [3:0] s_rd_data;

  logic rd_req, s_rd_req;
  int npass = 0;
  int ntot = 0;
  int done_cnt = 0;
  int s_done_cnt = 0;
  int d0;

  string       nm_q[$];
  logic [15:0] val_q[$];
  logic        sel_q[$];

  pla_out_activity_monitor #(.OUT_W(7), .CNT_W(16), .WINDOW(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .busy(busy), .done(done), .sat(sat), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  pla_out_activity_monitor #(.OUT_W(7), .CNT_W(4), .WINDOW(20)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_vec(s_in_vec), .busy(s_busy), .done(s_done), .sat(s_sat), .rd_addr(s_rd_addr), .rd_data(s_rd_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  // Issue a read and push its expected result; the monitor compares it when rd_data updates.
  task automatic rd(input logic which, input logic [3:0] a, input logic [15:0] e, input string nm);
    if (which) begin s_rd_addr = a; s_rd_req = 1'b1; end
    else       begin rd_addr = a;   rd_req = 1'b1;   end
    nm_q.push_back(nm);
    val_q.push_back(e);
    sel_q.push_back(which);
    @(negedge clk);
    rd_req = 1'b0;
    s_rd_req = 1'b0;
  endtask

  task automatic pulse_start(input logic which);
    if (which) s_start = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_start = 1'b0;
  endtask

  // Present a vector and hold it until accepted; returns at the negedge after the transfer.
  task automatic send(input logic which, input logic [6:0] v);
    int n = 0;
    if (which) begin s_in_vec = v; s_in_valid = 1'b1; end
    else       begin in_vec = v;   in_valid = 1'b1;   end
    while (((which ? s_in_ready : in_ready) == 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    s_in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: pops one expectation per read that the DUT answers.
  initial begin
    logic r, sr, w;
    logic [15:0] e;
    string nm;
    forever begin
      @(posedge clk);
      r = rd_req;
      sr = s_rd_req;
      #1;
      if (r || sr) begin
        if (nm_q.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
        else begin
          nm = nm_q.pop_front();
          e  = val_q.pop_front();
          w  = sel_q.pop_front();
          chk(nm, w ? 32'(s_rd_data) : 32'(rd_data), 32'(e));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done)   done_cnt++;
    if (s_done) s_done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_vec = '0; rd_addr = '0; rd_req = 1'b0;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_vec = '0; s_rd_addr = '0; s_rd_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat, 0);
    chk("rst_rd_data", rd_data, 0);
    rd(0, 4'd7, 16'd0, "rst_total");
    rd(0, 4'd8, 16'd0, "rst_samples");

    // Full-swing vectors, continuous valid
    pulse_start(0);
    chk("t1_armed_busy", busy, 1);
    chk("t1_armed_ready", in_ready, 1);
    d0 = done_cnt;
    send(0, 7'h00); send(0, 7'h7F); send(0, 7'h00); send(0, 7'h7F);
    in_valid = 1'b0;
    chk("t1_done_pulse", done, 1);
    chk("t1_report_busy", busy, 0);
    chk("t1_report_ready", in_ready, 0);
    @(negedge clk);
    chk("t1_done_one_cycle", done, 0);
    chk("t1_done_count", 32'(done_cnt - d0), 1);
    for (int i = 0; i < 7; i++) rd(0, 4'(i), 16'd3, $sformatf("t1_cnt%0d", i));
    rd(0, 4'd7, 16'd21, "t1_total");
    rd(0, 4'd8, 16'd4, "t1_samples");
    rd(0, 4'd9, 16'd0, "t1_addr9");
    chk("t1_sat", sat, 0);

    // Stalls between acceptances
    pulse_start(0);
    send(0, 7'h01); idle(1);
    chk("t2_ready_in_stall", in_ready, 1);
    send(0, 7'h03); idle(1);
    send(0, 7'h07); idle(1);
    send(0, 7'h07);
    in_valid = 1'b0;
    chk("t2_done", done, 1);
    @(negedge clk);
    chk("t2_idle_ready", in_ready, 0);
    rd(0, 4'd0, 16'd0, "t2_cnt0");
    rd(0, 4'd1, 16'd1, "t2_cnt1");
    rd(0, 4'd2, 16'd1, "t2_cnt2");
    rd(0, 4'd3, 16'd0, "t2_cnt3");
    rd(0, 4'd6, 16'd0, "t2_cnt6");
    rd(0, 4'd7, 16'd2, "t2_total");
    rd(0, 4'd8, 16'd4, "t2_samples");

    // Start while RUN is ignored
    pulse_start(0);
    d0 = done_cnt;
    send(0, 7'h00); send(0, 7'h01);
    in_valid = 1'b0;
    pulse_start(0);
    chk("t3_busy_after_start", busy, 1);
    send(0, 7'h03); send(0, 7'h03);
    in_valid = 1'b0;
    chk("t3_done", done, 1);
    idle(3);
    chk("t3_single_done", 32'(done_cnt - d0), 1);
    rd(0, 4'd0, 16'd1, "t3_cnt0");
    rd(0, 4'd1, 16'd1, "t3_cnt1");
    rd(0, 4'd7, 16'd2, "t3_total");
    rd(0, 4'd8, 16'd4, "t3_samples");

    // Reset mid-window
    pulse_start(0);
    send(0, 7'h00); send(0, 7'h7F); send(0, 7'h00);
    in_valid = 1'b0;
    rd(0, 4'd7, 16'd14, "t4_total_pre_rst");
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_ready", in_ready, 0);
    rd(0, 4'd7, 16'd0, "t4_total");
    rd(0, 4'd8, 16'd0, "t4_samples");
    rd(0, 4'd0, 16'd0, "t4_cnt0");
    idle(3);
    chk("t4_no_done", 32'(done_cnt - d0), 0);

    // Reset wins over start
    start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    chk("t4b_rst_wins", busy, 0);

    // Hamming-distance histogram
    pulse_start(0);
    send(0, 7'h00); send(0, 7'h03); send(0, 7'h03); send(0, 7'h7F);
    in_valid = 1'b0;
    @(negedge clk);
    rd(0, 4'd7, 16'd7, "t5_total");
`ifdef ACTIVITY_HAMMING_HIST_EN
    rd(0, 4'd10, 16'd1, "t5_hist2");
    rd(0, 4'd13, 16'd1, "t5_hist5");
    rd(0, 4'd9,  16'd0, "t5_hist1");
    rd(0, 4'd11, 16'd0, "t5_hist3");
`else
    rd(0, 4'd10, 16'd0, "t5_addr10");
    rd(0, 4'd13, 16'd0, "t5_addr13");
`endif

    // Saturation on the narrow instance
    pulse_start(1);
    for (int i = 0; i < 20; i++) begin
      send(1, 7'(i % 2));
      if (i == 15) chk("t6_sat_before", s_sat, 0);
      if (i == 16) chk("t6_sat_after", s_sat, 1);
    end
    s_in_valid = 1'b0;
    chk("t6_done", s_done, 1);
    @(negedge clk);
    chk("t6_done_count", 32'(s_done_cnt), 1);
    rd(1, 4'd0, 16'd15, "t6_cnt0");
    rd(1, 4'd7, 16'd15, "t6_total");
    rd(1, 4'd1, 16'd0,  "t6_cnt1");
    chk("t6_sat_sticky", s_sat, 1);
    pulse_start(1);
    chk("t6_sat_cleared", s_sat, 0);
    rd(1, 4'd0, 16'd0, "t6_cnt0_cleared");

    chk("sb_drained", 32'(nm_q.size()), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
